// File: rtl/regfile_mp_scrub.sv
// regfile_mp_scrub: 2R/1W register file with byte enables, write bypass, optional registered reads and zero-fill FSM
module regfile_mp_scrub #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int ZERO_REG0 = 1,
  parameter int READ_LAT = 0
) (
  input  logic              clk_o,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              init_done,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t st, st_nxt;
  logic [ADDR_W-1:0] clr_ptr, ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_old, wmerge, rd1, rd2;
  logic wq;
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH && !(ZERO_REG0 != 0 && a == '0);
  endfunction
  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      st <= CLEAR;
      clr_ptr <= '0;
    end else begin
      st <= st_nxt;
      clr_ptr <= ptr_nxt;
    end
  end
  always_comb begin
    st_nxt = st;
    ptr_nxt = clr_ptr;
    if (st == CLEAR) begin
      st_nxt = clr_ptr == ADDR_W'(DEPTH - 1) ? READY : CLEAR;
      ptr_nxt = clr_ptr == ADDR_W'(DEPTH - 1) ? '0 : clr_ptr + 1'b1;
    end else if (clr_req) begin
      st_nxt = CLEAR;
      ptr_nxt = '0;
    end
  end
  assign init_done = st == READY;
  assign wq = st == READY && !clr_req && reg_wr && ok(waddr);
  assign wr_old = 32'(waddr) < DEPTH ? mem[waddr] : '0;
  always_comb begin
    wmerge = wr_old;
    for (int i = 0; i < WIDTH / 8; i++)
      wmerge[8*i+:8] = wr_be[i] ? wdata[8*i+:8] : wr_old[8*i+:8];
  end
  always_ff @(posedge clk_o) begin
    if (st == CLEAR) mem[clr_ptr] <= '0;
    else if (wq) mem[waddr] <= wmerge;
  end
  assign rd1 = !(st == READY && ok(raddr1)) ? '0 : (wq && raddr1 == waddr) ? wmerge : mem[raddr1];
  assign rd2 = !(st == READY && ok(raddr2)) ? '0 : (wq && raddr2 == waddr) ? wmerge : mem[raddr2];
  if (READ_LAT != 0) begin : g_reg
    always_ff @(posedge clk_o) begin
      rdata1 <= (!rst_n || st_nxt != READY) ? '0 : rd1;
      rdata2 <= (!rst_n || st_nxt != READY) ? '0 : rd2;
    end
  end else begin : g_comb
    assign rdata1 = rd1;
    assign rdata2 = rd2;
  end
endmodule

// File: tb/tb_regfile_mp_scrub.sv
// tb_regfile_mp_scrub: directed checks of the default build and a 64-bit/16-entry registered-read build
module tb_regfile_mp_scrub;
  logic clk = 0;
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  logic rst_n, clr_req, init_done, reg_wr;
  logic [4:0] waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic [3:0] wr_be;
  logic b_rst_n, b_clr_req, b_init_done, b_reg_wr;
  logic [3:0] b_waddr, b_raddr1, b_raddr2;
  logic [63:0] b_wdata, b_rdata1, b_rdata2;
  logic [7:0] b_wr_be;
  regfile_mp_scrub u0 (
    .clk_o(clk), .rst_n(rst_n), .clr_req(clr_req), .init_done(init_done),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .wr_be(wr_be),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
  );
  regfile_mp_scrub #(.WIDTH(64), .DEPTH(16), .READ_LAT(1)) u1 (
    .clk_o(clk), .rst_n(b_rst_n), .clr_req(b_clr_req), .init_done(b_init_done),
    .reg_wr(b_reg_wr), .waddr(b_waddr), .wdata(b_wdata), .wr_be(b_wr_be),
    .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(b_rdata1), .rdata2(b_rdata2)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic count_init(input bit sel, input string tag, input int exp);
    int n = 0;
    while (!(sel ? b_init_done : init_done) && n < 100) begin
      tick;
      n++;
    end
    chk(tag, 64'(n), 64'(exp));
  endtask
  initial begin
    int n;
    logic [31:0] acc;
    rst_n = 0; clr_req = 0; reg_wr = 0; waddr = 0; wdata = 0; wr_be = 0; raddr1 = 0; raddr2 = 0;
    b_rst_n = 0; b_clr_req = 0; b_reg_wr = 0; b_waddr = 0; b_wdata = 0; b_wr_be = 0; b_raddr1 = 0; b_raddr2 = 0;
    tick;
    tick;
    chk("rst_init_done", 64'(init_done), 0);
    chk("rst_b_init_done", 64'(b_init_done), 0);
    chk("rst_b_rdata1", b_rdata1, 0);
    rst_n = 1;
    count_init(0, "clear_len", 32);
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      acc = acc | rdata1 | rdata2;
    end
    chk("clear_all_zero", 64'(acc), 0);
    reg_wr = 1; waddr = 5; wdata = 32'hDEADBEEF; wr_be = 4'hF;
    tick;
    reg_wr = 0; raddr1 = 5;
    #1 chk("wr_x5", 64'(rdata1), 64'hDEADBEEF);
    reg_wr = 1; waddr = 0; wdata = 32'h12345678; raddr2 = 0;
    #1 chk("x0_bypass", 64'(rdata2), 0);
    tick;
    reg_wr = 0;
    #1 chk("x0_zero", 64'(rdata2), 0);
    reg_wr = 1; waddr = 7; wdata = 32'h11111111; wr_be = 4'hF;
    tick;
    wdata = 32'hAABBCCDD; wr_be = 4'b0101; raddr1 = 7; raddr2 = 7;
    #1 chk("byp_p1", 64'(rdata1), 64'h11BB11DD);
    chk("byp_p2", 64'(rdata2), 64'h11BB11DD);
    tick;
    reg_wr = 0;
    #1 chk("byp_kept", 64'(rdata1), 64'h11BB11DD);
    reg_wr = 1; wdata = 32'hFFFFFFFF; wr_be = 4'h0;
    #1 chk("be0_bypass", 64'(rdata2), 64'h11BB11DD);
    tick;
    reg_wr = 0;
    #1 chk("be0_kept", 64'(rdata1), 64'h11BB11DD);
    reg_wr = 1; waddr = 9; wdata = 32'h1; wr_be = 4'hF; raddr1 = 9;
    tick;
    wdata = 32'h2;
    #1 chk("last_byp", 64'(rdata1), 2);
    tick;
    reg_wr = 0;
    #1 chk("last_wins", 64'(rdata1), 2);
    reg_wr = 1; waddr = 3; wdata = 32'h5;
    tick;
    reg_wr = 0; raddr1 = 3;
    #1 chk("wr_x3", 64'(rdata1), 5);
    clr_req = 1; reg_wr = 1; waddr = 4; wdata = 32'hABCD;
    tick;
    clr_req = 0; reg_wr = 0; raddr2 = 5;
    #1 chk("clr_init_drop", 64'(init_done), 0);
    chk("clr_rd_zero", 64'(rdata2), 0);
    n = 0;
    while (!init_done && n < 100) begin
      reg_wr = (n == 20); waddr = 2; wdata = 32'h77;
      tick;
      n++;
    end
    reg_wr = 0;
    chk("clr_len2", 64'(n), 32);
    raddr1 = 3; raddr2 = 2;
    #1 chk("x3_cleared", 64'(rdata1), 0);
    chk("x2_drop", 64'(rdata2), 0);
    raddr1 = 5; raddr2 = 4;
    #1 chk("x5_cleared", 64'(rdata1), 0);
    chk("x4_drop", 64'(rdata2), 0);
    clr_req = 1;
    tick;
    clr_req = 0;
    repeat (10) tick;
    rst_n = 0;
    tick;
    chk("mid_rst_init", 64'(init_done), 0);
    rst_n = 1;
    count_init(0, "restart_len", 32);
    b_rst_n = 1;
    count_init(1, "b_clear_len", 16);
    b_reg_wr = 1; b_waddr = 15; b_wdata = 64'h0123456789ABCDEF; b_wr_be = 8'hFF;
    tick;
    b_reg_wr = 0; b_raddr2 = 15;
    #1 chk("b_lat_before", b_rdata2, 0);
    tick;
    chk("b_lat_x15", b_rdata2, 64'h0123456789ABCDEF);
    b_reg_wr = 1; b_waddr = 3; b_wdata = 64'hAAAAAAAAAAAAAAAA; b_wr_be = 8'h0F; b_raddr1 = 3;
    tick;
    b_reg_wr = 0;
    chk("b_byp", b_rdata1, 64'h00000000AAAAAAAA);
    b_clr_req = 1;
    tick;
    b_clr_req = 0;
    chk("b_clr_rd_zero", b_rdata2, 0);
    chk("b_clr_init", 64'(b_init_done), 0);
    count_init(1, "b_clr_len", 16);
    tick;
    chk("b_x15_cleared", b_rdata2, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
